// File: rtl/iter_div.sv
// iter_div: iterative radix-2 restoring divider for RV32M div/divu/rem/remu.
//
// One quotient bit per cycle over WIDTH CALC cycles, then a single FIX cycle
// that applies the signed-result correction. Divide-by-zero and signed
// overflow bypass the datapath and finish the cycle after the start.
//
// Optional feature macro:
//   DIV_EARLY_OUT_EN - when defined, |dividend| < |divisor| (divisor != 0)
//                      also bypasses the datapath: quotient 0, remainder =
//                      dividend as given.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               abort the operation in flight (pipeline kill)
//   start, is_signed    request a division, two's-complement select
//   dividend, divisor   operands, captured on the accepted start
//   busy                high while an operation is iterating
//   done                one-cycle pulse, div_result valid
//   div_result          {remainder, quotient}, held until the next completion
module iter_div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] div_result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = '1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_neg;
    logic             b_neg;
    logic             is_ovf;
    logic             early;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    assign a_neg  = is_signed & dividend[WIDTH-1];
    assign b_neg  = is_signed & divisor[WIDTH-1];
    // MIN_NEG negates to itself, which is the correct unsigned magnitude.
    assign a_mag  = a_neg ? -dividend : dividend;
    assign b_mag  = b_neg ? -divisor  : divisor;
    assign is_ovf = is_signed && (dividend == MIN_NEG) && (divisor == ONES);

`ifdef DIV_EARLY_OUT_EN
    assign early  = (a_mag < b_mag) && (divisor != '0);
`else
    assign early  = 1'b0;
`endif

    // Trial subtract one bit wider than the operands; the top bit is the
    // borrow, so a clear MSB means the difference is non-negative.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        rem   <= '0;
                        quo   <= a_mag;
                        dvsr  <= b_mag;
                        cnt   <= '0;
                        if (divisor == '0) begin
                            div_result <= {dividend, ONES};
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else if (is_ovf) begin
                            div_result <= {{WIDTH{1'b0}}, dividend};
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else if (early) begin
                            div_result <= {dividend, {WIDTH{1'b0}}};
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (!diff[WIDTH]) begin
                        rem <= diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= S_FIX;
                end
                S_FIX: begin
                    div_result <= {neg_r ? -rem : rem, neg_q ? -quo : quo};
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
